ball_bitmap_arbiter: RTL and testbench
======================================

# ball_bitmap_arbiter

Shares one ball bitmap ROM stage (32x32, 8-bit RGB, one-cycle registered lookup, 8'hFF transparent) between up to NUM_BALLS on-screen ball objects. Each pixel cycle it picks at most one enabled ball whose rectangle covers the pixel and forwards that ball's offsets to the shared bitmap. One cycle later it routes the bitmap's drawing request back to the winning ball. It also keeps the per-ball enable mask, rotates priority per video frame, and reports ball overlap per frame. It sits between the ball square-object instances and the shared bitmap, ahead of the drawing-priority mux.

## Interface
Parameters:
- NUM_BALLS, 4: number of requesters, 2..8.
- ID_W, $clog2(NUM_BALLS): owner-index width.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- rotateEn  in  1  1 = rotate priority each frame; 0 = fixed priority, index 0 highest.
- ballInside  in  NUM_BALLS  per-ball "pixel inside rectangle".
- ballOffsetX, ballOffsetY  in  NUM_BALLS x 11  per-ball offset from the rectangle's top-left corner.
- ballEnableSet, ballEnableClr  in  NUM_BALLS  one-cycle set and clear pulses for the enable mask.
- bmpDrawingRequest  in  1  from the shared bitmap, valid one cycle after bmpInside.
- bmpOffsetX, bmpOffsetY  out  11  to the shared bitmap.
- bmpInside  out  1  to the shared bitmap.
- ownerId  out  ID_W  registered winner index.
- ownerValid  out  1  registered "a winner existed".
- ballDrawReq  out  NUM_BALLS  per-ball drawing request, one-hot or zero.
- enableMask  out  NUM_BALLS  current enable register.
- overlapFlag  out  1  at least one overlap pixel occurred in the previous complete frame.

## Operation
- Enable register, reset 0:
  - Per bit: clear has priority over set; set sets; otherwise hold.
  - New value is used from the next cycle.
- Priority pointer ptr (ID_W bits), reset 0:
  - On startOfFrame with rotateEn=1: ptr <= (ptr+1) mod NUM_BALLS, wrapping NUM_BALLS-1 -> 0 for non-power-of-2 counts.
  - On startOfFrame with rotateEn=0: ptr <= 0.
- Candidate vector: cand = ballInside & enableMask.
- Winner: the first set bit of cand, scanning from index ptr upward with wrap-around. The scan uses the current ptr; on a startOfFrame cycle the new ptr applies from the following cycle.
- Forwarding, combinational, same cycle:
  - bmpInside = |cand.
  - bmpOffsetX/Y = winner's offsets when |cand; otherwise 0.
- Owner stage, registered: ownerId <= winner index (0 if none); ownerValid <= |cand.
- ballDrawReq[i] = ownerValid & (ownerId==i) & bmpDrawingRequest. This is combinational from registers and the bitmap output.
- Overlap:
  - overlapNow = popcount(cand) >= 2.
  - Accumulator acc: on startOfFrame, overlapFlag <= acc | overlapNow and acc <= 0; otherwise acc <= acc | overlapNow.
  - overlapFlag reset 0.
- Reset, including mid-frame: enableMask, ptr, ownerId, ownerValid, acc and overlapFlag all go to 0 immediately. ballDrawReq = 0 while ownerValid = 0. bmp outputs follow the combinational rule, so they are 0 because enableMask = 0.

## Timing
- Zero-cycle path: ballInside/offset -> bmpInside/bmpOffset.
- One-cycle latency: pixel at cycle t -> ballDrawReq at t+1. This matches the bitmap's registered RGB, so overall ball latency equals every other single-stage object.
- Enable pulse at t affects cand from t+1.
- startOfFrame at t:
  - ptr changes at t+1.
  - overlapFlag updated at t+1 and holds for the whole frame.
- ballDrawReq must never have more than one bit set.
- A ball that is not enabled, or loses arbitration, gets ballDrawReq = 0 even where its own bitmap pixel is opaque.

## Test plan
- Reset, then ballEnableSet=4'b0011 and clr=4'b0001 in the same cycle -> enableMask=4'b0010 next cycle; all outputs 0 during reset.
- Ball 2 enabled, ballInside=4'b0100, offsets (5,7), bmpDrawingRequest=1 at t+1 -> bmpOffsetX/Y=5/7 at t; ownerId=2, ownerValid=1, ballDrawReq=4'b0100 at t+1. With bmpDrawingRequest=0 at t+1 -> ballDrawReq=0.
- rotateEn=0, all enabled, ballInside=4'b1010 -> winner 1. With rotateEn=1, after 2 startOfFrame pulses (ptr=2) -> winner 3; after 2 more (ptr=0) -> winner 1.
- NUM_BALLS=3, rotateEn=1 -> ptr sequence 0,1,2,0 over 3 frames; never 3.
- Two enabled balls overlap for one pixel in frame N -> overlapFlag=1 throughout frame N+1. No overlap in frame N+1 -> overlapFlag=0 in frame N+2. Overlap on the startOfFrame cycle itself is counted in the frame that is ending.
- resetN asserted mid-frame while ownerValid=1 -> ownerValid, ballDrawReq, enableMask and overlapFlag are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/ball_bitmap_arbiter_if.sv
// Ball-to-bitmap arbitration bundle.
// Carries per-ball geometry in, shared bitmap traffic and status out.
interface ball_bitmap_arbiter_if #(
  parameter int NUM_BALLS = 4,
  parameter int ID_W      = $clog2(NUM_BALLS)
);
  logic                        startOfFrame;
  logic                        rotateEn;
  logic [NUM_BALLS-1:0]        ballInside;
  logic [NUM_BALLS-1:0][10:0]  ballOffsetX;
  logic [NUM_BALLS-1:0][10:0]  ballOffsetY;
  logic [NUM_BALLS-1:0]        ballEnableSet;
  logic [NUM_BALLS-1:0]        ballEnableClr;
  logic                        bmpDrawingRequest;
  logic [10:0]                 bmpOffsetX;
  logic [10:0]                 bmpOffsetY;
  logic                        bmpInside;
  logic [ID_W-1:0]             ownerId;
  logic                        ownerValid;
  logic [NUM_BALLS-1:0]        ballDrawReq;
  logic [NUM_BALLS-1:0]        enableMask;
  logic                        overlapFlag;

  modport master (
    output startOfFrame, rotateEn, ballInside,
    output ballOffsetX, ballOffsetY,
    output ballEnableSet, ballEnableClr,
    output bmpDrawingRequest,
    input  bmpOffsetX, bmpOffsetY, bmpInside,
    input  ownerId, ownerValid, ballDrawReq,
    input  enableMask, overlapFlag
  );

  modport slave (
    input  startOfFrame, rotateEn, ballInside,
    input  ballOffsetX, ballOffsetY,
    input  ballEnableSet, ballEnableClr,
    input  bmpDrawingRequest,
    output bmpOffsetX, bmpOffsetY, bmpInside,
    output ownerId, ownerValid, ballDrawReq,
    output enableMask, overlapFlag
  );
endinterface

// File: rtl/ball_bitmap_arbiter.sv
// Shares one ball bitmap stage among NUM_BALLS ball objects.
// Rotating-priority pick per pixel, owner routed back one cycle later.
module ball_bitmap_arbiter #(
  parameter int NUM_BALLS = 4,
  parameter int ID_W      = $clog2(NUM_BALLS)
) (
  input logic                   clk,
  input logic                   resetN,
  ball_bitmap_arbiter_if.slave  bus
);

  logic [NUM_BALLS-1:0] en_q, en_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      oid_q;
  logic                 ov_q;
  logic                 acc_q, acc_d;
  logic                 flag_q, flag_d;

  logic [NUM_BALLS-1:0] cand;
  logic [ID_W:0]        idx;
  logic [ID_W-1:0]      win;
  logic                 found;
  logic                 seen;
  logic                 ovl_now;
  logic [NUM_BALLS-1:0] draw;

  assign cand = bus.ballInside & en_q;

  // Wrap-around scan starting at ptr; idx never exceeds 2*NUM_BALLS-2.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_BALLS; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_BALLS))
        idx = idx - (ID_W+1)'(NUM_BALLS);
      if (!found && cand[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    seen    = 1'b0;
    ovl_now = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (cand[i] && seen) ovl_now = 1'b1;
      seen = seen | cand[i];
    end
  end

  always_comb begin
    en_d = (en_q | bus.ballEnableSet) & ~bus.ballEnableClr;
    ptr_d  = ptr_q;
    acc_d  = acc_q | ovl_now;
    flag_d = flag_q;
    if (bus.startOfFrame) begin
      flag_d = acc_q | ovl_now;
      acc_d  = 1'b0;
      if (!bus.rotateEn)
        ptr_d = '0;
      else if (ptr_q == ID_W'(NUM_BALLS-1))
        ptr_d = '0;
      else
        ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      en_q   <= '0;
      ptr_q  <= '0;
      oid_q  <= '0;
      ov_q   <= 1'b0;
      acc_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      ptr_q  <= ptr_d;
      oid_q  <= win;
      ov_q   <= found;
      acc_q  <= acc_d;
      flag_q <= flag_d;
    end
  end

  always_comb begin
    draw = '0;
    for (int i = 0; i < NUM_BALLS; i++)
      draw[i] = ov_q && (oid_q == ID_W'(i))
                && bus.bmpDrawingRequest;
  end

  assign bus.bmpInside   = found;
  assign bus.bmpOffsetX  = found ? bus.ballOffsetX[win] : 11'd0;
  assign bus.bmpOffsetY  = found ? bus.ballOffsetY[win] : 11'd0;
  assign bus.ownerId     = oid_q;
  assign bus.ownerValid  = ov_q;
  assign bus.ballDrawReq = draw;
  assign bus.enableMask  = en_q;
  assign bus.overlapFlag = flag_q;

endmodule

// File: tb/tb_ball_bitmap_arbiter.sv
// Directed vector bench for ball_bitmap_arbiter.
// Four-ball table plus reset and three-ball wrap sequences.
module tb_ball_bitmap_arbiter;

  logic clk = 1'b0;
  logic resetN;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ball_bitmap_arbiter_if #(.NUM_BALLS(4)) b ();
  ball_bitmap_arbiter_if #(.NUM_BALLS(3)) b3 ();

  ball_bitmap_arbiter #(.NUM_BALLS(4)) dut (
    .clk(clk), .resetN(resetN), .bus(b)
  );
  ball_bitmap_arbiter #(.NUM_BALLS(3)) dut3 (
    .clk(clk), .resetN(resetN), .bus(b3)
  );

  typedef struct {
    logic [3:0]  set, clr, ins;
    logic        sof, rot, dreq;
    logic        bi;
    logic [10:0] ox, oy;
    logic [1:0]  oid;
    logic        ov;
    logic [3:0]  dr, mask;
    logic        flag;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(
    logic [3:0] set, logic [3:0] clr, logic [3:0] ins,
    logic sof, logic rot, logic dreq,
    logic bi, logic [10:0] ox, logic [10:0] oy,
    logic [1:0] oid, logic ov, logic [3:0] dr,
    logic [3:0] mask, logic flag);
    vec_t r;
    r.set = set; r.clr = clr; r.ins = ins;
    r.sof = sof; r.rot = rot; r.dreq = dreq;
    r.bi = bi; r.ox = ox; r.oy = oy;
    r.oid = oid; r.ov = ov; r.dr = dr;
    r.mask = mask; r.flag = flag;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // set clr ins sof rot dreq | bi ox oy oid ov dr mask flag
    v.push_back(mk(4'b0011,4'b0001,0,0,0,0, 0,0,0,0,0,0,4'b0000,0));
    v.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,0,4'b0010,0));
    v.push_back(mk(4'b0100,4'b0010,4'b0100,0,0,0,
                                            0,0,0,0,0,0,4'b0010,0));
    v.push_back(mk(0,0,4'b0100,0,0,0,       1,5,7,0,0,0,4'b0100,0));
    v.push_back(mk(0,0,0,0,0,1,             0,0,0,2,1,4'b0100,4'b0100,0));
    v.push_back(mk(0,0,4'b0100,0,0,0,       1,5,7,0,0,0,4'b0100,0));
    v.push_back(mk(0,0,0,0,0,0,             0,0,0,2,1,0,4'b0100,0));
    v.push_back(mk(4'b1111,0,0,0,0,0,       0,0,0,0,0,0,4'b0100,0));
    v.push_back(mk(0,0,4'b1010,0,0,0,       1,4,6,0,0,0,4'b1111,0));
    v.push_back(mk(0,0,0,0,0,1,             0,0,0,1,1,4'b0010,4'b1111,0));
    v.push_back(mk(0,0,0,1,1,0,             0,0,0,0,0,0,4'b1111,0));
    v.push_back(mk(0,0,4'b1010,0,0,0,       1,4,6,0,0,0,4'b1111,1));
    v.push_back(mk(0,0,0,1,1,0,             0,0,0,1,1,0,4'b1111,1));
    v.push_back(mk(0,0,4'b1010,0,0,0,       1,6,8,0,0,0,4'b1111,1));
    v.push_back(mk(0,0,0,0,0,1,             0,0,0,3,1,4'b1000,4'b1111,1));
    v.push_back(mk(0,0,0,1,1,0,             0,0,0,0,0,0,4'b1111,1));
    v.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,0,4'b1111,1));
    v.push_back(mk(0,0,0,1,1,0,             0,0,0,0,0,0,4'b1111,1));
    v.push_back(mk(0,0,4'b1010,0,0,0,       1,4,6,0,0,0,4'b1111,0));
    // overlap on the frame-start cycle closes out the ending frame
    v.push_back(mk(0,0,4'b0011,1,0,0,       1,3,5,1,1,0,4'b1111,0));
    v.push_back(mk(0,0,0,0,0,1,             0,0,0,0,1,4'b0001,4'b1111,1));
    v.push_back(mk(0,0,0,1,0,0,             0,0,0,0,0,0,4'b1111,1));
    v.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0,0,4'b1111,0));

    resetN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.ballOffsetX[i] = 11'(i + 3);
      b.ballOffsetY[i] = 11'(i + 5);
    end
    for (int i = 0; i < 3; i++) begin
      b3.ballOffsetX[i] = 11'(i + 3);
      b3.ballOffsetY[i] = 11'(i + 5);
    end
    b.startOfFrame = 0; b.rotateEn = 0;
    b.ballEnableSet = 4'b1111; b.ballEnableClr = 0;
    b.ballInside = 4'b1111; b.bmpDrawingRequest = 1;
    b3.startOfFrame = 0; b3.rotateEn = 1;
    b3.ballEnableSet = 0; b3.ballEnableClr = 0;
    b3.ballInside = 0; b3.bmpDrawingRequest = 0;

    repeat (2) tick();
    chk("rst.mask", 32'(b.enableMask), 0);
    chk("rst.bi", 32'(b.bmpInside), 0);
    chk("rst.ov", 32'(b.ownerValid), 0);
    chk("rst.dr", 32'(b.ballDrawReq), 0);
    chk("rst.flag", 32'(b.overlapFlag), 0);

    b.ballEnableSet = 0; b.ballInside = 0;
    b.bmpDrawingRequest = 0;
    resetN = 1'b1;
    tick();

    foreach (v[i]) begin
      b.ballEnableSet = v[i].set;
      b.ballEnableClr = v[i].clr;
      b.ballInside = v[i].ins;
      b.startOfFrame = v[i].sof;
      b.rotateEn = v[i].rot;
      b.bmpDrawingRequest = v[i].dreq;
      #1;
      chk($sformatf("r%0d.bi", i), 32'(b.bmpInside), 32'(v[i].bi));
      chk($sformatf("r%0d.ox", i), 32'(b.bmpOffsetX), 32'(v[i].ox));
      chk($sformatf("r%0d.oy", i), 32'(b.bmpOffsetY), 32'(v[i].oy));
      chk($sformatf("r%0d.oid", i), 32'(b.ownerId), 32'(v[i].oid));
      chk($sformatf("r%0d.ov", i), 32'(b.ownerValid), 32'(v[i].ov));
      chk($sformatf("r%0d.dr", i), 32'(b.ballDrawReq), 32'(v[i].dr));
      chk($sformatf("r%0d.mask", i), 32'(b.enableMask),
          32'(v[i].mask));
      chk($sformatf("r%0d.flag", i), 32'(b.overlapFlag),
          32'(v[i].flag));
      tick();
    end

    // mid-frame asynchronous reset with an active owner
    b.ballEnableSet = 0; b.ballEnableClr = 0;
    b.startOfFrame = 0; b.rotateEn = 0;
    b.bmpDrawingRequest = 0;
    b.ballInside = 4'b0011;
    tick();
    b.ballInside = 4'b0001; b.startOfFrame = 1;
    tick();
    b.ballInside = 4'b0001; b.startOfFrame = 0;
    b.bmpDrawingRequest = 1;
    #1;
    chk("pre.ov", 32'(b.ownerValid), 1);
    chk("pre.dr", 32'(b.ballDrawReq), 32'h1);
    chk("pre.flag", 32'(b.overlapFlag), 1);
    chk("pre.bi", 32'(b.bmpInside), 1);
    resetN = 1'b0;
    #1;
    chk("mid.ov", 32'(b.ownerValid), 0);
    chk("mid.dr", 32'(b.ballDrawReq), 0);
    chk("mid.mask", 32'(b.enableMask), 0);
    chk("mid.flag", 32'(b.overlapFlag), 0);
    chk("mid.bi", 32'(b.bmpInside), 0);
    tick();
    b.ballInside = 0; b.bmpDrawingRequest = 0;
    resetN = 1'b1;
    tick();

    // three-ball rotation must wrap 2 -> 0
    b3.ballEnableSet = 3'b111;
    tick();
    b3.ballEnableSet = 0;
    b3.ballInside = 3'b111;
    for (int f = 0; f < 7; f++) begin
      #1;
      chk($sformatf("n3.f%0d.ox", f), 32'(b3.bmpOffsetX),
          32'((f % 3) + 3));
      b3.startOfFrame = 1;
      tick();
      b3.startOfFrame = 0;
      tick();
    end
    #1;
    chk("n3.end.oid", 32'(b3.ownerId), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
